conv_window: RTL and testbench

Sliding-window generator that sits directly upstream of the convolution kernel datapath. It accepts a raster-ordered pixel stream, one pixel per valid cycle, and holds KERN_DIM−1 image lines in line buffers. For every fully populated window position (valid convolution, no padding) it presents a flattened KERN_DIM×KERN_DIM window plus a valid strobe. The window and strobe connect straight to the kernel's `din`/`din_vld` (KERN_SIZE = KERN_DIM²).

---
 rtl/conv_pkg.sv | 13 +
 rtl/functions_pkg.sv | 13 +
 rtl/conv_line_buffer.sv | 24 ++
 rtl/conv_window.sv | 117 +++++++++++
 tb/tb_conv_window.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Types and helpers shared by the window generator and the convolution kernel.
package conv_pkg;

    localparam int PIX_W = 8;

    typedef logic signed [PIX_W-1:0] pix_t;

    // Flattened window index: r=0 oldest line, c=0 oldest column.
    function automatic int win_idx(input int r, input int c, input int kdim);
        return r * kdim + c;
    endfunction

endpackage

// File: rtl/functions_pkg.sv
// Shared elaboration-time helpers.
package functions_pkg;

    // Minimum bit width to hold values 0..value-1; never below 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage, addressed by column, read-before-write.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Left unreset so it maps onto RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

endmodule

// File: rtl/conv_window.sv
// Sliding KERN_DIM x KERN_DIM window generator over a raster pixel stream.
// Optional CONV_WINDOW_SOF_EN adds a sof input that forces the current pixel to (0,0).
module conv_window
    import functions_pkg::*;
    import conv_pkg::*;
#(
    parameter int DIN_WIDTH  = 8,
    parameter int KERN_DIM   = 3,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          din_vld,
    input  logic [DIN_WIDTH-1:0]                          din,
`ifdef CONV_WINDOW_SOF_EN
    input  logic                                          sof,
`endif
    output logic                                          win_vld,
    output logic [KERN_DIM*KERN_DIM-1:0][DIN_WIDTH-1:0]   win
);

    localparam int CW  = clog2(IMG_WIDTH);
    localparam int RW  = clog2(IMG_HEIGHT);
    localparam int NLB = KERN_DIM - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERN_DIM - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERN_DIM - 1);

    logic [CW-1:0] col, pos_col;
    logic [RW-1:0] row, pos_row;
    logic          restart;

`ifdef CONV_WINDOW_SOF_EN
    assign restart = din_vld & sof;
`else
    assign restart = 1'b0;
`endif

    // Position of the pixel being accepted this cycle.
    assign pos_col = restart ? '0 : col;
    assign pos_row = restart ? '0 : row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (din_vld) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // Line buffer chain: each line moves up one buffer as the new pixel lands at the bottom.
    logic [NLB-1:0][DIN_WIDTH-1:0]      lb_rd, lb_wd;
    logic [KERN_DIM-1:0][DIN_WIDTH-1:0] new_col;

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        if (k == NLB - 1) begin : g_last
            assign lb_wd[k] = din;
        end else begin : g_mid
            assign lb_wd[k] = lb_rd[k+1];
        end

        conv_line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (DIN_WIDTH),
            .AW    (CW)
        ) u_lb (
            .clk   (clk),
            .we    (din_vld),
            .addr  (pos_col),
            .wdata (lb_wd[k]),
            .rdata (lb_rd[k])
        );

        assign new_col[k] = lb_rd[k];
    end

    assign new_col[KERN_DIM-1] = din;

    logic [DIN_WIDTH-1:0] win_q [KERN_DIM][KERN_DIM];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_vld <= 1'b0;
            for (int r = 0; r < KERN_DIM; r++)
                for (int c = 0; c < KERN_DIM; c++)
                    win_q[r][c] <= '0;
        end else begin
            // Gating on position keeps columns from a previous line out of valid windows.
            win_vld <= din_vld && (pos_col >= COL_FIRST) && (pos_row >= ROW_FIRST);
            if (din_vld) begin
                for (int r = 0; r < KERN_DIM; r++) begin
                    for (int c = 0; c < KERN_DIM - 1; c++)
                        win_q[r][c] <= win_q[r][c+1];
                    win_q[r][KERN_DIM-1] <= new_col[r];
                end
            end
        end
    end

    for (genvar r = 0; r < KERN_DIM; r++) begin : g_row
        for (genvar c = 0; c < KERN_DIM; c++) begin : g_col
            localparam int IDX = win_idx(r, c, KERN_DIM);
            assign win[IDX] = win_q[r][c];
        end
    end

endmodule

// File: tb/tb_conv_window.sv
// Directed bench for conv_window with a 3x3 kernel over a 5x4 image.
module tb_conv_window;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int IW = 5;
    localparam int IH = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  din_vld;
    logic [DW-1:0]         din;
    logic                  sof_in;
    logic                  win_vld;
    logic [K*K-1:0][DW-1:0] win;

    int checks   = 0;
    int failures = 0;

    logic [K*K*DW-1:0] cap[$];

    always #5 clk = ~clk;

    conv_window #(
        .DIN_WIDTH  (DW),
        .KERN_DIM   (K),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .din_vld (din_vld),
        .din     (din),
`ifdef CONV_WINDOW_SOF_EN
        .sof     (sof_in),
`endif
        .win_vld (win_vld),
        .win     (win)
    );

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected window with top-left at image (r0,c0), pixel = base + row*16 + col.
    function automatic logic [71:0] mk_win(input logic [7:0] base, input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*8 +: 8] = 8'(int'(base) + (r0 + r) * 16 + c0 + c);
        return w;
    endfunction

    // Drive one cycle, then sample just after the edge that consumed it.
    task automatic drive(input logic [7:0] p, input logic v, input logic s);
        din     = p;
        din_vld = v;
        sof_in  = s;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        sof_in  = 1'b0;
        if (!v) begin
            check("gap_vld", {71'b0, win_vld}, 72'd0);
        end else if (win_vld) begin
            cap.push_back(win);
            check("win_newest", {64'b0, win[K*K-1]}, {64'b0, p});
        end
    endtask

    task automatic frame(input logic [7:0] base, input bit toggle);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                drive(8'(int'(base) + r * 16 + c), 1'b1, 1'b0);
                if (toggle)
                    drive(8'hEE, 1'b0, 1'b0);
            end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base, input int start);
        for (int i = 0; i < 6; i++)
            check(tag, cap[start+i], mk_win(base, i / 3, i % 3));
    endtask

    int n;

    initial begin
        reset_n = 1'b0;
        din_vld = 1'b0;
        din     = '0;
        sof_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", {71'b0, win_vld}, 72'd0);
        check("rst_win", win, 72'd0);
        reset_n = 1'b1;

        // Continuous frame
        cap.delete();
        frame(8'h00, 1'b0);
        check("cont_count", 72'(cap.size()), 72'd6);
        check("cont_first", cap[0], 72'h22_21_20_12_11_10_02_01_00);
        check("cont_last",  cap[5], 72'h34_33_32_24_23_22_14_13_12);
        check_frame("cont_win", 8'h00, 0);

        // din_vld toggling, gap after every pixel
        cap.delete();
        frame(8'h00, 1'b1);
        check("tog_count", 72'(cap.size()), 72'd6);
        check_frame("tog_win", 8'h00, 0);

        // Two back-to-back frames, second offset by 0x80
        cap.delete();
        frame(8'h00, 1'b0);
        n = cap.size();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++)
                drive(8'(8'h80 + r * 16 + c), 1'b1, 1'b0);
        check("f2_early_vld", 72'(cap.size() - n), 72'd0);
        for (int r = 2; r < IH; r++)
            for (int c = 0; c < IW; c++)
                drive(8'(8'h80 + r * 16 + c), 1'b1, 1'b0);
        check("f2_count", 72'(cap.size()), 72'd12);
        check("f2_first", cap[6], 72'hA2_A1_A0_92_91_90_82_81_80);
        check_frame("f2_win", 8'h80, 6);

        // Reset mid-frame after pixel 0x23
        cap.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IW; c++)
                if (r < 2 || c <= 3)
                    drive(8'(r * 16 + c), 1'b1, 1'b0);
        check("pre_rst_count", 72'(cap.size()), 72'd2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_vld", {71'b0, win_vld}, 72'd0);
        check("async_rst_win", win, 72'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cap.delete();
        frame(8'h40, 1'b0);
        check("post_rst_count", 72'(cap.size()), 72'd6);
        check("post_rst_first", cap[0], 72'h62_61_60_52_51_50_42_41_40);
        check_frame("post_rst_win", 8'h40, 0);

`ifdef CONV_WINDOW_SOF_EN
        // Abort partway, then sof restarts the frame; a sof without din_vld is ignored
        cap.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++)
                if (r < 1 || c <= 1)
                    drive(8'(r * 16 + c), 1'b1, 1'b0);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                drive(8'(r * 16 + c), 1'b1, (r == 0 && c == 0));
                if (r == 2 && c == 1)
                    drive(8'h55, 1'b0, 1'b1);
            end
        check("sof_count", 72'(cap.size()), 72'd6);
        check_frame("sof_win", 8'h00, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
